// File: rtl/gf2017_mul_fold.sv
// gf2017_mul_fold: sequential 11x11 shift-and-add multiplier whose 22-bit
// product is folded with 2^11 = 31 (mod 2017) into a 21-bit reducer input.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept (forced low during reset)
//   din_a      multiplicand, any 11-bit value
//   din_b      multiplier, any 11-bit value
//   out_valid  dout_p holds a folded product
//   out_ready  consumer accepts dout_p
//   dout_p     folded product, congruent to din_a*din_b mod 2017
//   busy       multiply or fold in progress
module gf2017_mul_fold #(
  parameter int WIDTH     = 11,
  parameter int OUT_WIDTH = 21,
  parameter int FOLD_K    = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     din_a,
  input  logic [WIDTH-1:0]     din_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout_p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FOLD,
    S_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [OUT_WIDTH-1:0] fold;

  // hi*2^11 + lo == hi*31 + lo (mod 2017); max 2046*31+2047 fits easily
  assign fold = OUT_WIDTH'(acc_q[PW-1:WIDTH]) * OUT_WIDTH'(FOLD_K)
              + OUT_WIDTH'(acc_q[WIDTH-1:0]);

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_MUL) || (state_q == S_FOLD);
  assign dout_p    = dout_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = {{WIDTH{1'b0}}, din_a};
          b_d     = din_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        dout_d  = fold;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_gf2017_mul_fold.sv
// tb_gf2017_mul_fold: directed scoreboard bench for gf2017_mul_fold.
// Expected products are hand-folded constants queued at issue time.
module tb_gf2017_mul_fold;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] din_a;
  logic [10:0] din_b;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] dout_p;
  logic        busy;

  gf2017_mul_fold dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .din_b     (din_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_p    (dout_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops on every handshake, checks hold stability under stall.
  logic        hold = 1'b0;
  logic [20:0] hold_v;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (hold) chk("hold_stable", 32'(dout_p), 32'(hold_v));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0d expected none", dout_p);
        end else begin
          chk("dout_p", 32'(dout_p), 32'(exp_q.pop_front()));
        end
        hold = 1'b0;
      end else begin
        hold   = 1'b1;
        hold_v = dout_p;
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic issue(input logic [10:0] a, input logic [10:0] b,
                       input int exp, input bit track);
    int n = 0;
    din_a    = a;
    din_b    = b;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) chk("accept_timeout", 32'(n), 0);
    if (track) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    din_a    = 11'($urandom);
    din_b    = 11'($urandom);
  endtask

  task automatic wait_out(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained", 32'(out_valid), 0);
  endtask

  task automatic run_op(input logic [10:0] a, input logic [10:0] b,
                        input int exp, input string tag);
    int lat, bc;
    issue(a, b, exp, 1'b1);
    wait_out(lat, bc);
    chk({tag, "_latency"}, 32'(lat), 12);
    drain();
  endtask

  logic [10:0] va [8] = '{11'd2047, 11'd0, 11'd1, 11'd2047,
                          11'd1024, 11'd100, 11'd2016, 11'd1234};
  logic [10:0] vb [8] = '{11'd2047, 11'd1234, 11'd1, 11'd1,
                          11'd2, 11'd200, 11'd1, 11'd0};
  int          ve [8] = '{63427, 0, 1, 2047, 31, 1847, 2016, 0};

  logic [10:0] sa [4] = '{11'd3, 11'd2047, 11'd45, 11'd2016};
  logic [10:0] sb [4] = '{11'd7, 11'd2047, 11'd1000, 11'd2016};
  int          se [4] = '{21, 63427, 2643, 62528};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, k, t, last;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din_a     = '0;
    din_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dout_p", 32'(dout_p), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // 2016*2016: latency and busy window
    issue(11'd2016, 11'd2016, 62528, 1'b1);
    wait_out(lat, bc);
    chk("max_latency", 32'(lat), 12);
    chk("max_busy_cycles", 32'(bc), 12);
    chk("out_busy_low", 32'(busy), 0);
    drain();

    for (int i = 0; i < 8; i++) run_op(va[i], vb[i], ve[i], "vec");

    // stalled output: value held, in_ready low, pulsed operand ignored
    out_ready = 1'b0;
    issue(11'd45, 11'd1000, 2643, 1'b1);
    wait_out(lat, bc);
    chk("stall_latency", 32'(lat), 12);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_dout_p", 32'(dout_p), 2643);
      in_valid = (i == 2);
      din_a    = 11'd1;
      din_b    = 11'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stall_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    drain();
    run_op(11'd7, 11'd9, 63, "after_stall");

    // reset during MUL abandons the operation
    issue(11'd2016, 11'd2016, 0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_dout_p", 32'(dout_p), 0);
    chk("mid_busy_low", 32'(busy), 0);
    run_op(11'd3, 11'd5, 15, "post_abort");

    // back-to-back stream: accept edges are 14 edges apart
    k        = 0;
    t        = 0;
    last     = 0;
    din_a    = sa[0];
    din_b    = sb[0];
    in_valid = 1'b1;
    while (k < 4 && t < 200) begin
      if (in_ready) begin
        exp_q.push_back(se[k]);
        if (k > 0) chk("stream_interval", 32'(t - last), 14);
        last = t;
        k++;
      end
      @(posedge clk); #1;
      t++;
      if (k < 4) begin
        din_a = sa[k];
        din_b = sb[k];
      end
    end
    in_valid = 1'b0;
    chk("stream_accepts", 32'(k), 4);
    wait_out(lat, bc);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
